// File: rtl/flash_copy_sequencer_if.sv
// SPI byte-engine and destination-RAM bus between the copy sequencer (master)
// and its environment (slave).
interface flash_copy_sequencer_if #(
   parameter int DST_AW = 12
);
   logic              spi_we;
   logic [7:0]        spi_di;
   logic [7:0]        spi_do;
   logic              spi_ready;
   logic              spi_ss_reset;
   logic [3:0]        mem_we;
   logic [DST_AW-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (
      output spi_we, spi_di, spi_ss_reset, mem_we, mem_addr, mem_wdata,
      input  spi_do, spi_ready
   );

   modport slave (
      input  spi_we, spi_di, spi_ss_reset, mem_we, mem_addr, mem_wdata,
      output spi_do, spi_ready
   );
endinterface

// File: rtl/flash_copy_sequencer.sv
// Copies a burst of 32-bit words from SPI flash (READ opcode + 24-bit address)
// into word-addressed RAM, with abort, sticky done and chip-select release.
module flash_copy_sequencer #(
   parameter int          DST_AW   = 12,
   parameter int          LEN_W    = 12,
   parameter logic [7:0]  READ_CMD = 8'h03
) (
   input  logic                   clk,
   input  logic                   resetq,
   input  logic                   start,
   input  logic                   abort,
   input  logic [23:0]            src_addr,
   input  logic [DST_AW-1:0]      dst_addr,
   input  logic [LEN_W-1:0]       length,
   input  logic                   done_ack,
   output logic                   busy,
   output logic                   done,
   output logic                   aborted,
   flash_copy_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADR2, S_ADR1, S_ADR0, S_RDBYTE, S_STORE, S_FINISH
   } state_t;

   typedef enum logic [1:0] {PH_REQ, PH_ISSUE, PH_SKIP, PH_WAIT} phase_t;

   state_t            state_q, state_d;
   phase_t            phase_q, phase_d;
   logic [23:0]       src_q, src_d;
   logic [DST_AW-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  count_q, count_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic              abort_pend_q, abort_pend_d;
   logic              done_q, done_d;
   logic              aborted_q, aborted_d;
   logic              byte_state;
   logic              abort_now;

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         state_q      <= S_IDLE;
         phase_q      <= PH_REQ;
         src_q        <= '0;
         addr_q       <= '0;
         count_q      <= '0;
         wdata_q      <= '0;
         byte_idx_q   <= '0;
         abort_pend_q <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         src_q        <= src_d;
         addr_q       <= addr_d;
         count_q      <= count_d;
         wdata_q      <= wdata_d;
         byte_idx_q   <= byte_idx_d;
         abort_pend_q <= abort_pend_d;
         done_q       <= done_d;
         aborted_q    <= aborted_d;
      end
   end

   assign byte_state = (state_q == S_CMD) || (state_q == S_ADR2) || (state_q == S_ADR1) ||
                       (state_q == S_ADR0) || (state_q == S_RDBYTE);
   assign abort_now  = abort_pend_q | abort;

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      src_d        = src_q;
      addr_d       = addr_q;
      count_d      = count_q;
      wdata_d      = wdata_q;
      byte_idx_d   = byte_idx_q;
      abort_pend_d = abort_pend_q;
      done_d       = done_q;
      aborted_d    = aborted_q;

      // done_ack is overridden below when FINISH sets done in the same cycle
      if (done_ack) begin
         done_d    = 1'b0;
         aborted_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               abort_pend_d = 1'b0;
               if (length == '0) begin
                  state_d = S_FINISH;
               end else begin
                  src_d      = src_addr;
                  addr_d     = dst_addr;
                  count_d    = length;
                  byte_idx_d = '0;
                  done_d     = 1'b0;
                  aborted_d  = 1'b0;
                  phase_d    = PH_REQ;
                  state_d    = S_CMD;
               end
            end
         end
         S_CMD, S_ADR2, S_ADR1, S_ADR0, S_RDBYTE: begin
            abort_pend_d = abort_now;
            case (phase_q)
               PH_REQ: begin
                  if (abort_now)          state_d = S_FINISH;
                  else if (bus.spi_ready) phase_d = PH_ISSUE;
               end
               PH_ISSUE: phase_d = PH_SKIP;
               PH_SKIP:  phase_d = PH_WAIT;
               PH_WAIT: begin
                  if (bus.spi_ready) begin
                     phase_d = PH_REQ;
                     if (abort_now) begin
                        state_d = S_FINISH;
                     end else begin
                        case (state_q)
                           S_CMD:   state_d = S_ADR2;
                           S_ADR2:  state_d = S_ADR1;
                           S_ADR1:  state_d = S_ADR0;
                           S_ADR0:  state_d = S_RDBYTE;
                           default: begin
                              // shift right so the first byte lands in [7:0]
                              wdata_d    = {bus.spi_do, wdata_q[31:8]};
                              byte_idx_d = byte_idx_q + 2'd1;
                              if (byte_idx_q == 2'd3) state_d = S_STORE;
                           end
                        endcase
                     end
                  end
               end
               default: phase_d = PH_REQ;
            endcase
         end
         S_STORE: begin
            abort_pend_d = abort_now;
            addr_d       = addr_q + DST_AW'(1);
            count_d      = count_q - LEN_W'(1);
            if (abort_now || count_q == LEN_W'(1)) state_d = S_FINISH;
            else                                   state_d = S_RDBYTE;
         end
         S_FINISH: begin
            done_d       = 1'b1;
            aborted_d    = abort_pend_q;
            abort_pend_d = 1'b0;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      case (state_q)
         S_CMD:   bus.spi_di = READ_CMD;
         S_ADR2:  bus.spi_di = src_q[23:16];
         S_ADR1:  bus.spi_di = src_q[15:8];
         S_ADR0:  bus.spi_di = src_q[7:0];
         default: bus.spi_di = 8'h00;
      endcase
   end

   assign bus.spi_we       = byte_state && (phase_q == PH_ISSUE);
   assign bus.spi_ss_reset = (state_q == S_FINISH);
   assign bus.mem_we       = (state_q == S_STORE) ? 4'b1111 : 4'b0000;
   assign bus.mem_addr     = addr_q;
   assign bus.mem_wdata    = wdata_q;
   assign busy             = byte_state || (state_q == S_STORE);
   assign done             = done_q;
   assign aborted          = aborted_q;

endmodule

// File: tb/tb_flash_copy_sequencer.sv
// Scoreboard bench for flash_copy_sequencer: directed copies with a behavioural
// SPI flash engine; expected SPI bytes and RAM writes are queued per test.
module tb_flash_copy_sequencer;

   logic        clk = 1'b0;
   logic        resetq = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [23:0] src_addr = '0;
   logic [11:0] dst_addr = '0;
   logic [11:0] length = '0;
   logic        done_ack = 1'b0;
   logic        busy, done, aborted;

   int vectors = 0;
   int miscompares = 0;
   int spi_cnt = 0;
   int mem_cnt = 0;
   int ss_cnt = 0;

   logic [7:0]  exp_spi[$];
   logic [43:0] exp_mem[$];

   flash_copy_sequencer_if #(.DST_AW(12)) bus ();

   flash_copy_sequencer #(.DST_AW(12), .LEN_W(12), .READ_CMD(8'h03)) dut (
      .clk(clk), .resetq(resetq), .start(start), .abort(abort),
      .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
      .done_ack(done_ack), .busy(busy), .done(done), .aborted(aborted),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // flash content model: byte at address a is (a[3:0]+1)*0x11
   function automatic logic [7:0] fbyte(input logic [23:0] a);
      logic [7:0] n;
      n = {4'h0, a[3:0]} + 8'd1;
      return n * 8'h11;
   endfunction

   // SPI byte engine: 2 busy cycles per byte, returns flash data after the header
   initial begin
      int nb;
      int bcnt;
      logic [23:0] fa;
      logic [7:0]  resp;
      nb = 0; bcnt = 0; fa = '0; resp = '0;
      bus.spi_ready = 1'b1;
      bus.spi_do = 8'h00;
      forever begin
         @(negedge clk);
         if (!resetq) begin
            nb = 0; bcnt = 0; bus.spi_ready = 1'b1;
         end else begin
            if (bcnt > 0) begin
               bcnt--;
               if (bcnt == 0) begin
                  bus.spi_ready = 1'b1;
                  bus.spi_do = resp;
               end
            end else if (bus.spi_we) begin
               bus.spi_ready = 1'b0;
               bcnt = 2;
               case (nb)
                  1: fa[23:16] = bus.spi_di;
                  2: fa[15:8]  = bus.spi_di;
                  3: fa[7:0]   = bus.spi_di;
                  default: ;
               endcase
               resp = (nb >= 4) ? fbyte(fa + 24'(nb - 4)) : 8'hFF;
               nb++;
            end
            if (bus.spi_ss_reset) nb = 0;
         end
      end
   end

   // monitor: pops expectations whenever the DUT issues a byte or a write
   initial begin
      logic [7:0]  es;
      logic [43:0] em;
      forever begin
         @(negedge clk);
         if (resetq) begin
            if (bus.spi_we) begin
               spi_cnt++;
               check("spi_expected", 64'(exp_spi.size() != 0), 64'd1);
               if (exp_spi.size() != 0) begin
                  es = exp_spi.pop_front();
                  check("spi_di", 64'(bus.spi_di), 64'(es));
               end
            end
            if (bus.mem_we != 4'b0000) begin
               mem_cnt++;
               check("mem_we_mask", 64'(bus.mem_we), 64'hF);
               check("mem_expected", 64'(exp_mem.size() != 0), 64'd1);
               if (exp_mem.size() != 0) begin
                  em = exp_mem.pop_front();
                  check("mem_addr_data", 64'({bus.mem_addr, bus.mem_wdata}), 64'(em));
               end
            end
            if (bus.spi_ss_reset) ss_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_test();
      spi_cnt = 0; mem_cnt = 0; ss_cnt = 0;
   endtask

   task automatic push_hdr(input logic [23:0] s, input int data_bytes);
      exp_spi.push_back(8'h03);
      exp_spi.push_back(s[23:16]);
      exp_spi.push_back(s[15:8]);
      exp_spi.push_back(s[7:0]);
      for (int i = 0; i < data_bytes; i++) exp_spi.push_back(8'h00);
   endtask

   task automatic kick(input logic [23:0] s, input logic [11:0] d, input logic [11:0] l);
      src_addr = s; dst_addr = d; length = l;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while (!done && n < budget) begin
         tick();
         n++;
      end
      if (!done) check({name, "_timeout"}, 64'(n), 64'(budget + 1));
   endtask

   task automatic wait_spi(input int target, input int budget);
      int n;
      n = 0;
      while (spi_cnt < target && n < budget) begin
         tick();
         n++;
      end
      if (spi_cnt < target) check("spi_wait_timeout", 64'(spi_cnt), 64'(target));
   endtask

   task automatic end_test(input string name, input int ss_exp, input logic ab_exp);
      tick();
      check({name, "_done"}, 64'(done), 64'd1);
      check({name, "_aborted"}, 64'(aborted), 64'(ab_exp));
      check({name, "_busy"}, 64'(busy), 64'd0);
      check({name, "_ss_reset_count"}, 64'(ss_cnt), 64'(ss_exp));
      check({name, "_spi_left"}, 64'(exp_spi.size()), 64'd0);
      check({name, "_mem_left"}, 64'(exp_mem.size()), 64'd0);
   endtask

   task automatic ack();
      done_ack = 1'b1;
      tick();
      done_ack = 1'b0;
      check("ack_done_clear", 64'({done, aborted}), 64'd0);
   endtask

   initial begin
      int n;
      // reset state
      #1;
      check("rst_flags", 64'({busy, done, aborted}), 64'd0);
      check("rst_strobes", 64'({bus.spi_we, bus.spi_ss_reset, bus.mem_we}), 64'd0);
      check("rst_data", 64'({bus.mem_addr, bus.mem_wdata, bus.spi_di}), 64'd0);
      tick(); tick();
      resetq = 1'b1;
      tick();

      // basic two-word copy
      begin_test();
      push_hdr(24'h020000, 8);
      exp_mem.push_back({12'h010, 32'h44332211});
      exp_mem.push_back({12'h011, 32'h88776655});
      kick(24'h020000, 12'h010, 12'd2);
      check("copy_busy", 64'(busy), 64'd1);
      wait_done("copy", 400);
      end_test("copy", 1, 1'b0);
      check("copy_spi_count", 64'(spi_cnt), 64'd12);
      check("copy_mem_count", 64'(mem_cnt), 64'd2);
      ack();

      // zero length
      begin_test();
      kick(24'h000000, 12'h000, 12'd0);
      n = 1;
      while (!done && n < 3) begin
         tick();
         n++;
      end
      check("len0_done_in_3", 64'(done), 64'd1);
      end_test("len0", 1, 1'b0);
      check("len0_no_traffic", 64'(spi_cnt + mem_cnt), 64'd0);
      ack();

      // abort during 2nd data byte of word 0
      begin_test();
      push_hdr(24'h000040, 2);
      kick(24'h000040, 12'h100, 12'd4);
      wait_spi(6, 200);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_done("abort", 200);
      end_test("abort", 1, 1'b1);
      check("abort_no_mem", 64'(mem_cnt), 64'd0);
      check("abort_spi_count", 64'(spi_cnt), 64'd6);
      ack();

      // destination address wrap
      begin_test();
      push_hdr(24'h000100, 8);
      exp_mem.push_back({12'hFFF, 32'h44332211});
      exp_mem.push_back({12'h000, 32'h88776655});
      kick(24'h000100, 12'hFFF, 12'd2);
      wait_done("wrap", 400);
      end_test("wrap", 1, 1'b0);
      ack();

      // start while busy ignored, done_ack coincident with completion
      begin_test();
      push_hdr(24'h000008, 4);
      exp_mem.push_back({12'h020, 32'hCCBBAA99});
      kick(24'h000008, 12'h020, 12'd1);
      tick(); tick();
      kick(24'h000000, 12'h030, 12'd3);
      n = 0;
      while (!bus.spi_ss_reset && n < 300) begin
         tick();
         n++;
      end
      check("coinc_finish_seen", 64'(bus.spi_ss_reset), 64'd1);
      done_ack = 1'b1;
      tick();
      done_ack = 1'b0;
      check("coinc_done_kept", 64'(done), 64'd1);
      tick(); tick();
      check("coinc_still_idle", 64'(busy), 64'd0);
      end_test("coinc", 1, 1'b0);
      check("coinc_mem_count", 64'(mem_cnt), 64'd1);
      ack();

      // reset during RDBYTE, then a normal copy
      begin_test();
      push_hdr(24'h000000, 8);
      kick(24'h000000, 12'h200, 12'd2);
      wait_spi(6, 200);
      resetq = 1'b0;
      exp_spi.delete();
      #1;
      check("midrst_flags", 64'({busy, done, aborted}), 64'd0);
      check("midrst_strobes", 64'({bus.spi_we, bus.spi_ss_reset, bus.mem_we}), 64'd0);
      check("midrst_data", 64'({bus.mem_addr, bus.mem_wdata, bus.spi_di}), 64'd0);
      tick(); tick();
      resetq = 1'b1;
      tick();
      check("midrst_no_mem", 64'(mem_cnt), 64'd0);
      begin_test();
      push_hdr(24'h000004, 4);
      exp_mem.push_back({12'h055, 32'h88776655});
      kick(24'h000004, 12'h055, 12'd1);
      wait_done("after_rst", 300);
      end_test("after_rst", 1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
